// File: rtl/alu_operand_stage.sv
// ALU operand stage between decode and execute: operand selection, result forwarding,
// load-use hazard detection and a registered operand pair behind a valid/ready handshake.
module alu_operand_stage #(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              alu_asel,
  input  logic [1:0]              alu_bsel,
  input  logic                    rs2_store,
  input  logic [4:0]              rs1_addr,
  input  logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         reg_data1,
  input  logic [XLEN-1:0]         reg_data2,
  input  logic [XLEN-1:0]         pc,
  input  logic [XLEN-1:0]         imm_val,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    flush,
  input  logic                    cnt_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         alu_op1,
  output logic [XLEN-1:0]         alu_op2,
  output logic [XLEN-1:0]         store_data,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [1:0] ASEL_REG = 2'b01;
  localparam logic [1:0] ASEL_PC  = 2'b10;
  localparam logic [1:0] BSEL_REG = 2'b01;
  localparam logic [1:0] BSEL_IMM = 2'b10;
  localparam logic [1:0] BSEL_C4  = 2'b11;

  localparam logic [XLEN-1:0]  CONST_FOUR = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [XLEN-1:0]  op1_q, op1_d;
  logic [XLEN-1:0]  op2_q, op2_d;
  logic [XLEN-1:0]  st_q, st_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  rs1_val, rs2_val;
  logic             rs1_pend, rs2_pend;
  logic             rs1_used, rs2_used;
  logic             hazard;
  logic             accept;

  // Scan oldest to youngest so the lowest matching index overrides the rest.
  always_comb begin
    rs1_val  = reg_data1;
    rs1_pend = 1'b0;
    rs2_val  = reg_data2;
    rs2_pend = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[5*i +: 5] == rs1_addr) && (rs1_addr != 5'd0)) begin
        rs1_val  = fwd_data[XLEN*i +: XLEN];
        rs1_pend = fwd_pending[i];
      end
      if (fwd_valid[i] && (fwd_rd[5*i +: 5] == rs2_addr) && (rs2_addr != 5'd0)) begin
        rs2_val  = fwd_data[XLEN*i +: XLEN];
        rs2_pend = fwd_pending[i];
      end
    end
  end

  always_comb begin
    rs1_used = (alu_asel == ASEL_REG);
    rs2_used = (alu_bsel == BSEL_REG) || rs2_store;
    hazard   = in_valid && ((rs1_used && rs1_pend) || (rs2_used && rs2_pend));
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never waits on valid, and a holder keeps its payload stable until it transfers.
  always_comb begin
    in_ready = !hazard && (!valid_q || out_ready);
    accept   = in_valid && in_ready && !flush;
  end

  always_comb begin
    unique case (alu_asel)
      ASEL_REG: op1_d = rs1_val;
      ASEL_PC:  op1_d = pc;
      default:  op1_d = '0;
    endcase
    unique case (alu_bsel)
      BSEL_REG: op2_d = rs2_val;
      BSEL_IMM: op2_d = imm_val;
      BSEL_C4:  op2_d = CONST_FOUR;
      default:  op2_d = '0;
    endcase
    st_d = rs2_val;
  end

  // Flush only drops valid; operand registers are left as they are.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hazard && !flush && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op1_q <= '0;
      op2_q <= '0;
      st_q  <= '0;
    end else if (accept) begin
      op1_q <= op1_d;
      op2_q <= op2_d;
      st_q  <= st_d;
    end
  end

  assign out_valid  = valid_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign store_data = st_q;
  assign stall_cnt  = cnt_q;

endmodule
